capture_trigger: RTL
====================

# capture_trigger

Capture-trigger controller that drives the `stop` input of the circular audio sample buffer. It sits directly upstream of that buffer on the same sample clock and watches the same 16-bit signed PCM stream. Once armed, it lets the buffer fill completely, then waits for the signal magnitude to cross a threshold. It then lets a programmable number of post-trigger samples through and freezes the buffer so downstream correlation logic can read a stable window.

## Interface
- `LENGTH`, 240 — buffer depth; number of samples written after arming before a trigger is accepted (1..255).
- `POST_SAMPLES`, 120 — samples written after the trigger sample before freeze (0..65535).
- `clk` in 1 — sample clock, one PCM sample per rising edge; same clock as the buffer write clock.
- `reset` in 1 — asynchronous, active-high reset.
- `pcm` in 16 — signed PCM sample, valid every cycle.
- `threshold` in 16 — unsigned magnitude threshold, held static while armed.
- `arm` in 1 — single-cycle start/re-arm request.
- `stop` out 1 — registered freeze to the buffer; buffer writes while 0.
- `armed` out 1 — registered; 1 in ARMED state only.
- `done` out 1 — registered single-cycle pulse on the edge where `stop` rises due to capture completion.

## Operation
- Magnitude: `mag = |pcm|` as unsigned 17-bit compare domain, so −32768 → 32768. Hit condition: `mag >= threshold`. `threshold` = 0 hits on any sample.
- `above` register: holds the previous cycle's hit result. It is set to 1 on reset and on the edge that leaves IDLE or STOPPED, and is updated every cycle in FILL and ARMED.
- States:
  - IDLE: `stop`=1. `arm` → FILL.
  - FILL: `stop`=0. A fill counter counts edges; after LENGTH edges in FILL → ARMED. `arm` is ignored.
  - ARMED: `stop`=0, `armed`=1. A trigger event → POST with the post counter cleared, or directly → STOPPED if POST_SAMPLES=0. `arm` is ignored.
  - POST: `stop`=0. The post counter increments per edge; when the count reaches POST_SAMPLES → STOPPED. `arm` is ignored.
  - STOPPED: `stop`=1. `arm` → FILL, with the fill counter cleared.
- Trigger event: defined in the Configuration section.
- Only IDLE and STOPPED respond to `arm`.

## Timing
- Reset values: state=IDLE, `stop`=1, `armed`=0, `done`=0, counters=0, `above`=1. Reset is asynchronous and takes effect mid-capture with no completion pulse.
- `arm` sampled at edge a: `stop` falls after edge a. The buffer's first write is at edge a+1. `armed` rises after edge a+LENGTH.
- Trigger sample present at edge k (ARMED): that sample is written by the buffer at edge k. `stop` and `done` rise after edge k+POST_SAMPLES. Samples from edges k+1..k+POST_SAMPLES are written; no further samples are written.
- POST_SAMPLES=0: `stop` and `done` rise after edge k, combinationally decided from `pcm` at edge k.
- `done` is high for exactly one cycle; `stop` holds until the next `arm`.
- A trigger condition during FILL is ignored, but FILL still updates `above`.
- Simultaneous `arm` with a trigger condition in STOPPED: `arm` wins; go to FILL.

## Configuration
- `CAPTURE_TRIGGER_EDGE_EN` defined: the trigger event is a rising crossing, i.e. a hit this cycle with `above`=0. A signal already above threshold when ARMED is entered must first drop below threshold.
- Not defined: the trigger event is level-sensitive, i.e. any hit in ARMED. `above` is still maintained but unused.

## Test plan
- Reset then `arm` one cycle, `pcm`=0, `threshold`=1000, LENGTH=240 → `stop`=0 from the next cycle. `armed` rises exactly 240 edges after `arm`. `stop` stays 0 indefinitely.
- Armed, `pcm`=−32768 at edge k, `threshold`=32768, POST_SAMPLES=120 → `stop` and `done` rise after edge k+120. `done` is 1 for one cycle only. `stop` holds 1 for 500 further cycles.
- POST_SAMPLES=0, `pcm`=2000 at edge k, `threshold`=2000 → `stop` rises after edge k.
- Edge mode: `pcm`=5000 throughout fill and arming, `threshold`=1000 → no trigger. Then `pcm`=0 for one cycle, then 5000 → trigger on the 5000 sample. Level build: trigger on the first ARMED cycle.
- Hit during FILL (`pcm`=30000 at fill edge 10) → no trigger. Asserting `arm` in POST → ignored, with completion timing unchanged.
- `reset` asserted mid-POST → `stop`=1 immediately (asynchronous) and `done` never pulses. A subsequent `arm` → full LENGTH refill before `armed`.

Source files
------------

// File: rtl/capture_trigger.sv
// Capture-trigger controller: freezes a circular sample buffer a programmable number of samples after a threshold hit.
// Define CAPTURE_TRIGGER_EDGE_EN for rising-crossing triggering; otherwise any hit while armed triggers.
module capture_trigger #(
    parameter int unsigned LENGTH       = 240,
    parameter int unsigned POST_SAMPLES = 120
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] pcm,
    input  logic [15:0] threshold,
    input  logic        arm,
    output logic        stop,
    output logic        armed,
    output logic        done
);

    // state   | meaning
    // IDLE    | after reset, buffer frozen, waiting for arm
    // FILL    | buffer filling, triggers ignored
    // ARMED   | buffer full, waiting for trigger
    // POST    | writing post-trigger samples
    // STOPPED | capture complete, buffer frozen until re-arm
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FILL    = 3'd1,
        ARMED   = 3'd2,
        POST    = 3'd3,
        STOPPED = 3'd4
    } state_t;

    localparam logic [7:0]  FILL_LAST = 8'(LENGTH - 1);
    localparam logic [15:0] POST_LAST = 16'(POST_SAMPLES - 1);

    state_t      state, next_state;
    logic [7:0]  fill_cnt, fill_next;
    logic [15:0] post_cnt, post_next;
    logic        above, above_next;
    logic        done_next;

    logic [16:0] pcm_ext;
    logic [16:0] mag;
    logic        hit;
    logic        trigger;

    // 17-bit domain so that -32768 maps to +32768 without wrapping
    assign pcm_ext = {pcm[15], pcm};
    assign mag     = pcm[15] ? (~pcm_ext + 17'd1) : pcm_ext;
    assign hit     = (mag >= {1'b0, threshold});

`ifdef CAPTURE_TRIGGER_EDGE_EN
    assign trigger = hit && !above;
`else
    // Level triggering: the crossing term is absorbed by the plain hit.
    assign trigger = hit || (hit && !above);
`endif

    always_comb begin
        next_state = state;
        fill_next  = fill_cnt;
        post_next  = post_cnt;
        above_next = above;
        done_next  = 1'b0;
        case (state)
            IDLE, STOPPED: begin
                if (arm) begin
                    next_state = FILL;
                    fill_next  = 8'd0;
                    above_next = 1'b1;
                end
            end
            FILL: begin
                above_next = hit;
                if (fill_cnt == FILL_LAST) begin
                    next_state = ARMED;
                end else begin
                    fill_next = fill_cnt + 8'd1;
                end
            end
            ARMED: begin
                above_next = hit;
                if (trigger) begin
                    if (POST_SAMPLES == 0) begin
                        next_state = STOPPED;
                        done_next  = 1'b1;
                    end else begin
                        next_state = POST;
                        post_next  = 16'd0;
                    end
                end
            end
            POST: begin
                if (post_cnt == POST_LAST) begin
                    next_state = STOPPED;
                    done_next  = 1'b1;
                end else begin
                    post_next = post_cnt + 16'd1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            fill_cnt <= 8'd0;
            post_cnt <= 16'd0;
            above    <= 1'b1;
            stop     <= 1'b1;
            armed    <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= next_state;
            fill_cnt <= fill_next;
            post_cnt <= post_next;
            above    <= above_next;
            stop     <= (next_state == IDLE) || (next_state == STOPPED);
            armed    <= (next_state == ARMED);
            done     <= done_next;
        end
    end

endmodule
